// File: rtl/weight_fetch_ctrl_pkg.sv
// Shared ANN parameter defaults and weight-fetch FSM state encodings.
// The LOAD state exists only when WFETCH_LOAD_EN is defined.
package weight_fetch_ctrl_pkg;

  localparam int WF_DEPTH  = 30;
  localparam int WF_ADDR_W = 5;
  localparam int WF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
`ifdef WFETCH_LOAD_EN
    ,
    ST_LOAD  = 2'd3
`endif
  } wf_state_e;

endpackage

// File: rtl/wfetch_skid_buf.sv
// Two-entry output FIFO for the weight stream; head entry is always presented.
// Callers guarantee no push when full and no pop when empty.
module wfetch_skid_buf #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head_data
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= {W{1'b0}};
      mem[1] <= {W{1'b0}};
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Streams DEPTH weights out of a BRAM with one-cycle read latency into a valid/ready port.
// Optional macro WFETCH_LOAD_EN adds a LOAD state that writes DEPTH words into the BRAM.
module weight_fetch_ctrl
  import weight_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH  = WF_DEPTH,
  parameter int ADDR_W = WF_ADDR_W,
  parameter int DATA_W = WF_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              BRAM_EN,
  output logic              BRAM_WE,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic [DATA_W-1:0] BRAM_DI,
  input  logic [DATA_W-1:0] BRAM_DO,
`ifdef WFETCH_LOAD_EN
  input  logic              LOAD_START,
  input  logic [DATA_W-1:0] LOAD_DATA,
  input  logic              LOAD_VALID,
  output logic              LOAD_READY,
`endif
  output logic [DATA_W-1:0] W_DATA,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic              W_LAST
);

  wf_state_e         state;
  wf_state_e         state_next;
  logic [ADDR_W-1:0] cnt;
  logic              pend;
  logic              pend_last;
  logic              done_flag;
  logic [1:0]        fifo_count;
  logic [DATA_W:0]   head;
  logic              pop;
  logic              at_last;
  logic              issue;
  logic              load_wr;

  assign pop     = W_VALID && W_READY;
  assign at_last = (cnt == ADDR_W'(DEPTH - 1));
  // Occupancy after this cycle's pop must leave room for the word being requested.
  assign issue   = (state == ST_FETCH) &&
                   (({1'b0, fifo_count} + {2'b00, pend} - {2'b00, pop}) < 3'd2);
`ifdef WFETCH_LOAD_EN
  assign load_wr = (state == ST_LOAD) && LOAD_VALID;
`else
  assign load_wr = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; LOAD_START outranks START in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
`ifdef WFETCH_LOAD_EN
        if (LOAD_START) state_next = ST_LOAD;
        else if (START) state_next = ST_FETCH;
        else            state_next = ST_IDLE;
`else
        if (START) state_next = ST_FETCH;
        else       state_next = ST_IDLE;
`endif
      end
      ST_FETCH: begin
        if (issue && at_last) state_next = ST_DRAIN;
        else                  state_next = ST_FETCH;
      end
      ST_DRAIN: begin
        if (pop && W_LAST) state_next = ST_IDLE;
        else               state_next = ST_DRAIN;
      end
`ifdef WFETCH_LOAD_EN
      ST_LOAD: begin
        if (load_wr && at_last) state_next = ST_IDLE;
        else                    state_next = ST_LOAD;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // BRAM port and load handshake, decoded from state and counter.
  always_comb begin
    BRAM_EN   = 1'b0;
    BRAM_WE   = 1'b0;
    BRAM_ADDR = {ADDR_W{1'b0}};
    BRAM_DI   = {DATA_W{1'b0}};
`ifdef WFETCH_LOAD_EN
    LOAD_READY = 1'b0;
`endif
    case (state)
      ST_FETCH: begin
        BRAM_EN   = issue;
        BRAM_ADDR = cnt;
      end
`ifdef WFETCH_LOAD_EN
      ST_LOAD: begin
        LOAD_READY = 1'b1;
        BRAM_EN    = load_wr;
        BRAM_WE    = load_wr;
        BRAM_ADDR  = cnt;
        if (load_wr) BRAM_DI = LOAD_DATA;
        else         BRAM_DI = {DATA_W{1'b0}};
      end
`endif
      default: begin
        BRAM_EN = 1'b0;
      end
    endcase
  end

  // Address counter, read-pending tracking and completion pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= {ADDR_W{1'b0}};
      pend      <= 1'b0;
      pend_last <= 1'b0;
      done_flag <= 1'b0;
    end else begin
      pend      <= issue;
      pend_last <= issue && at_last;
      done_flag <= (state != ST_IDLE) && (state_next == ST_IDLE);
      if (issue || load_wr) begin
        cnt <= at_last ? {ADDR_W{1'b0}} : cnt + ADDR_W'(1);
      end
    end
  end

  wfetch_skid_buf #(
    .W(DATA_W + 1)
  ) u_buf (
    .clk      (CLK),
    .rst      (RST),
    .push     (pend),
    .push_data({pend_last, BRAM_DO}),
    .pop      (pop),
    .count    (fifo_count),
    .head_data(head)
  );

  assign BUSY    = (state != ST_IDLE);
  assign DONE    = done_flag;
  assign W_VALID = (fifo_count != 2'd0);
  assign W_DATA  = head[DATA_W-1:0];
  assign W_LAST  = W_VALID && head[DATA_W];

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl: a DEPTH=30 instance with a falling-edge BRAM model
// and a DEPTH=1 instance; exercises the WFETCH_LOAD_EN load path when that macro is defined.
module tb_weight_fetch_ctrl;

  localparam int DEPTH = 30;
  localparam int AW    = 5;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_di;
  logic [DW-1:0] bram_do;
  logic [DW-1:0] w_data;
  logic          w_valid;
  logic          w_ready;
  logic          w_last;
`ifdef WFETCH_LOAD_EN
  logic          load_start;
  logic [DW-1:0] load_data;
  logic          load_valid;
  logic          load_ready;
  logic          load_ready_b;
`endif

  logic          start_b;
  logic          busy_b;
  logic          done_b;
  logic          en_b;
  logic          we_b;
  logic [0:0]    addr_b;
  logic [DW-1:0] di_b;
  logic [DW-1:0] do_b;
  logic [DW-1:0] wd_b;
  logic          wv_b;
  logic          wl_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  weight_fetch_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(clk), .RST(rst), .START(start), .BUSY(busy), .DONE(done),
    .BRAM_EN(bram_en), .BRAM_WE(bram_we), .BRAM_ADDR(bram_addr),
    .BRAM_DI(bram_di), .BRAM_DO(bram_do),
`ifdef WFETCH_LOAD_EN
    .LOAD_START(load_start), .LOAD_DATA(load_data),
    .LOAD_VALID(load_valid), .LOAD_READY(load_ready),
`endif
    .W_DATA(w_data), .W_VALID(w_valid), .W_READY(w_ready), .W_LAST(w_last)
  );

  weight_fetch_ctrl #(.DEPTH(1), .ADDR_W(1), .DATA_W(DW)) dut_d1 (
    .CLK(clk), .RST(rst), .START(start_b), .BUSY(busy_b), .DONE(done_b),
    .BRAM_EN(en_b), .BRAM_WE(we_b), .BRAM_ADDR(addr_b),
    .BRAM_DI(di_b), .BRAM_DO(do_b),
`ifdef WFETCH_LOAD_EN
    .LOAD_START(1'b0), .LOAD_DATA(16'd0),
    .LOAD_VALID(1'b0), .LOAD_READY(load_ready_b),
`endif
    .W_DATA(wd_b), .W_VALID(wv_b), .W_READY(1'b1), .W_LAST(wl_b)
  );

  // BRAM model: address/enable registered on the rising edge, data updated on the falling edge.
  logic [DW-1:0] mem [0:DEPTH-1];
  logic          fill;
  logic          lat_en;
  logic [AW-1:0] lat_addr;
  logic          lat_b;

  always @(posedge clk) begin
    lat_en   <= rst ? 1'b0 : (bram_en && !bram_we);
    lat_addr <= bram_addr;
    lat_b    <= rst ? 1'b0 : en_b;
    if (fill) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(100 + i);
    end else if (bram_en && bram_we) begin
      mem[bram_addr] <= bram_di;
    end
  end

  always @(negedge clk) begin
    if (lat_en) bram_do <= mem[lat_addr];
    if (lat_b)  do_b    <= 16'd100;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch stream with a repeating 4-cycle W_READY pattern; optional START retrigger / RST at word k.
  task automatic run_stream(input logic [3:0] pat, input logic [15:0] base,
                            input int restart_at, input int rst_at);
    int   k, cyc, issued, dones, first_cyc, last_cyc, done_cyc;
    logic restarted, popv;
    k = 0; issued = 0; dones = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
    restarted = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (cyc < 140) begin
      w_ready = pat[cyc % 4];
      start   = (k == restart_at) && !restarted;
      if (start) restarted = 1'b1;
      if (k == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_w_valid", w_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_bram_en", bram_en, 0);
        return;
      end
      #1;
      popv = w_valid && w_ready;
      if (bram_en) begin
        check("rd_gate", (issued - k - int'(popv)) < 2, 1);
        check("rd_addr", bram_addr, issued);
        check("rd_we", bram_we, 0);
        issued++;
      end
      if (!busy) check("idle_bram_en", bram_en, 0);
      if (w_valid && first_cyc < 0) first_cyc = cyc;
      if (popv) begin
        check("w_data", w_data, base + k);
        check("w_last", w_last, k == DEPTH - 1);
        if (k == DEPTH - 1) last_cyc = cyc;
        k++;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      tick();
      cyc++;
    end
    start   = 1'b0;
    w_ready = 1'b1;
    check("word_count", k, DEPTH);
    check("done_count", dones, 1);
    check("done_latency", done_cyc, last_cyc + 1);
    if (pat == 4'hF) check("first_valid_latency", first_cyc, 2);
  endtask

  initial begin
    int got_b, dones_b, word_cyc_b, done_cyc_b;
    rst = 1'b1; start = 1'b0; w_ready = 1'b0; fill = 1'b1; start_b = 1'b0;
`ifdef WFETCH_LOAD_EN
    load_start = 1'b0; load_data = 16'd0; load_valid = 1'b0;
`endif
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_w_valid", w_valid, 0);
    check("reset_w_last", w_last, 0);
    check("reset_w_data", w_data, 0);
    check("reset_bram_en", bram_en, 0);
    check("reset_bram_we", bram_we, 0);
    check("reset_bram_addr", bram_addr, 0);
    check("reset_bram_di", bram_di, 0);
    check("reset_d1_w_valid", wv_b, 0);
    fill = 1'b0;
    rst  = 1'b0;
    w_ready = 1'b1;
    tick();

    run_stream(4'hF, 16'd100, -1, -1);
    run_stream(4'b1001, 16'd100, -1, -1);
    run_stream(4'hF, 16'd100, 10, -1);
    run_stream(4'hF, 16'd100, -1, 15);
    run_stream(4'hF, 16'd100, -1, -1);

    // DEPTH=1 instance: a single word flagged last, then DONE.
    got_b = 0; dones_b = 0; word_cyc_b = -1; done_cyc_b = -1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (en_b) begin
        check("d1_addr", addr_b, 0);
        check("d1_we", we_b, 0);
        check("d1_di", di_b, 0);
      end
      if (wv_b) begin
        check("d1_data", wd_b, 100);
        check("d1_last", wl_b, 1);
        got_b++;
        word_cyc_b = c;
      end
      if (done_b) begin
        dones_b++;
        done_cyc_b = c;
      end
      tick();
    end
    check("d1_words", got_b, 1);
    check("d1_first_latency", word_cyc_b, 2);
    check("d1_dones", dones_b, 1);
    check("d1_done_latency", done_cyc_b, word_cyc_b + 1);
    check("d1_idle", busy_b, 0);

`ifdef WFETCH_LOAD_EN
    begin
      int w, ld_dones, ld_done_cyc, last_wr_cyc;
      w = 0; ld_dones = 0; ld_done_cyc = -1; last_wr_cyc = -1;
      load_start = 1'b1;
      start      = 1'b1;
      tick();
      load_start = 1'b0;
      start      = 1'b0;
      for (int c = 0; c < 80; c++) begin
        load_valid = (w < DEPTH) && (c % 3 != 2);
        load_data  = 16'hA000 + 16'(w);
        #1;
        if (load_valid) begin
          check("ld_ready", load_ready, 1);
          check("ld_en", bram_en, 1);
          check("ld_we", bram_we, 1);
          check("ld_addr", bram_addr, w);
          check("ld_di", bram_di, 16'hA000 + w);
          if (w == DEPTH - 1) last_wr_cyc = c;
          w++;
        end
        if (done) begin
          ld_dones++;
          ld_done_cyc = c;
        end
        tick();
      end
      load_valid = 1'b0;
      check("ld_writes", w, DEPTH);
      check("ld_dones", ld_dones, 1);
      check("ld_done_latency", ld_done_cyc, last_wr_cyc + 1);
      check("ld_idle", busy, 0);
      run_stream(4'hF, 16'hA000, -1, -1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/weight_fetch_ctrl.md
WEIGHT_FETCH_CTRL -- requirements
Module: weight_fetch_ctrl

Interface
- REQ-001 SHALL have parameter DEPTH, default 30: number of weight words per BRAM.
- REQ-002 SHALL have parameter ADDR_W, default 5: BRAM address width.
- REQ-003 SHALL have parameter DATA_W, default 16: weight word width.
- REQ-004 SHALL have ports as follows; one clock, reset synchronous active-high.
  - CLK  in  1: sole clock; all state updates on the rising edge.
  - RST  in  1: synchronous active-high reset.
  - START  in  1: one-cycle request to stream all DEPTH weights.
  - BUSY  out  1: high while not IDLE.
  - DONE  out  1: one-cycle pulse when an operation completes.
  - BRAM_EN  out  1: BRAM enable.
  - BRAM_WE  out  1: BRAM write enable.
  - BRAM_ADDR  out  ADDR_W: BRAM address.
  - BRAM_DI  out  DATA_W: BRAM write data.
  - BRAM_DO  in  DATA_W: BRAM read data; the BRAM updates it on the falling edge of CLK.
  - W_DATA  out  DATA_W: streamed weight.
  - W_VALID  out  1: W_DATA valid.
  - W_READY  in  1: consumer accepts the word.
  - W_LAST  out  1: marks word DEPTH-1.

Function
- REQ-005 SHALL implement FSM states IDLE, FETCH, DRAIN, plus LOAD when WFETCH_LOAD_EN is defined.
- REQ-006 IDLE -> FETCH SHALL occur on START sampled high; a START arriving while BUSY SHALL be ignored.
- REQ-007 In FETCH, BRAM_EN and BRAM_ADDR SHALL be driven combinationally from the state and the read counter.
  - BRAM_WE SHALL be 0 in FETCH.
  - A read SHALL issue only when (buffer count + read pending − pop this cycle) < 2.
- REQ-008 Read latency SHALL be exactly one cycle.
  - A read issued in cycle n SHALL be captured from BRAM_DO into the output buffer at the rising edge ending cycle n+1.
  - With W_READY held high, the first W_VALID SHALL appear two cycles after START is sampled.
- REQ-009 The output buffer SHALL be a 2-entry FIFO.
  - W_DATA/W_VALID SHALL present the head entry.
  - A word SHALL transfer when W_VALID && W_READY.
  - W_DATA SHALL hold stable while W_VALID && !W_READY.
- REQ-010 With W_READY held high, sustained throughput SHALL be one word per cycle.
  - No word SHALL be dropped or duplicated under any W_READY pattern.
- REQ-011 Read addresses SHALL run 0..DEPTH-1 with no wrap-around.
  - After issuing address DEPTH-1 the FSM SHALL enter DRAIN.
- REQ-012 W_LAST SHALL be high with W_VALID only for the word read from address DEPTH-1.
- REQ-013 DRAIN SHALL go to IDLE in the cycle after the W_LAST transfer, asserting DONE for one cycle on that transition.
- REQ-014 DEPTH=1 SHALL be supported: FETCH lasts one cycle, then DRAIN.
- REQ-015 Outside FETCH and LOAD, BRAM_EN, BRAM_WE and BRAM_ADDR SHALL be 0.

Reset
- REQ-016 RST SHALL force IDLE, clear all counters and the buffer, and discard any pending read; this applies mid-operation as well.
- REQ-017 Outputs after reset SHALL be: BUSY=0, DONE=0, W_VALID=0, W_LAST=0, W_DATA=0, BRAM_EN=0, BRAM_WE=0, BRAM_ADDR=0, BRAM_DI=0.
- REQ-018 RST SHALL take priority over START and over LOAD_START.

Configuration
- REQ-019 Macro WFETCH_LOAD_EN defined SHALL add the following inputs/outputs:
  - LOAD_START in 1
  - LOAD_DATA in DATA_W
  - LOAD_VALID in 1
  - LOAD_READY out 1
- REQ-020 With WFETCH_LOAD_EN defined, the LOAD state SHALL behave as follows:
  - IDLE -> LOAD SHALL occur on LOAD_START.
  - LOAD_READY SHALL be 1 in LOAD.
  - Each cycle with LOAD_VALID high SHALL drive BRAM_EN=1, BRAM_WE=1, BRAM_ADDR=write counter and BRAM_DI=LOAD_DATA, then increment the write counter.
  - After DEPTH writes the FSM SHALL return to IDLE with a DONE pulse.
- REQ-021 If LOAD_START and START are both high in IDLE, LOAD SHALL win and START SHALL be dropped.
- REQ-022 Without WFETCH_LOAD_EN, the load ports and the LOAD state SHALL not exist, and BRAM_WE and BRAM_DI SHALL be tied 0.

Structure
- REQ-023 The shared ANN parameter package SHALL hold DEPTH/ADDR_W/DATA_W defaults and the FSM state encodings.
- REQ-024 The 2-entry output FIFO SHALL be the sub-module wfetch_skid_buf (count, push, pop, head data).

Verification
- REQ-025 The bench SHALL drive W_READY=1 and pulse START with the BRAM model preloaded with mem[i]=i+100.
  - Required: words 100..129 on consecutive cycles; first W_VALID 2 cycles after START; W_LAST on 129; DONE one cycle later.
- REQ-026 The bench SHALL toggle W_READY 1,0,0,1 repeating.
  - Required: exactly 30 transfers in order; BRAM_EN never raised while count+pending = 2.
- REQ-027 The bench SHALL pulse START again at word 10.
  - Required: the stream is unaffected; a single DONE.
- REQ-028 The bench SHALL assert RST at word 15 of a stream.
  - Required: next cycle W_VALID=0, BUSY=0, BRAM_EN=0; a new START restarts at word 100.
- REQ-029 With WFETCH_LOAD_EN defined, the bench SHALL load 30 words 0xA000+i with LOAD_VALID gapped every third cycle, then fetch.
  - Required: writes to addresses 0..29 with BRAM_WE=1; DONE after the 30th write; fetch returns 0xA000..0xA01D.
- REQ-030 The bench SHALL build with DEPTH=1.
  - Required: one word with W_LAST=1, then DONE.
